// File: rtl/linesensor_timer.sv
// Linear image sensor timing generator.
// Produces the sensor clock (sclk), the start/integrate pulse (sst) and a
// one-clk readout trigger (otrig). It sequences single-shot, N-frame or
// free-running acquisitions, using an exposure length sampled at each frame.
// Every frame runs LEAD -> EXPOSE -> TAIL -> READ. All phase changes happen on
// the internal tick, which coincides with the falling edge of sclk.
module linesensor_timer #(
   parameter int unsigned DIV        = 8,    // clk cycles per sclk period (even, >= 4)
   parameter int unsigned CNT_W      = 32,   // exposure / phase counter width
   parameter int unsigned FRM_W      = 16,   // frame request / frame count width
   parameter int unsigned LEAD_TICKS = 5,    // ticks sst is high before exposure
   parameter int unsigned TAIL_TICKS = 88,   // ticks from sst fall to otrig
   parameter int unsigned READ_TICKS = 286   // ticks reserved for readout
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             start,
   input  logic             stop,
   input  logic             abort,
   input  logic [CNT_W-1:0] exposure,
   input  logic [FRM_W-1:0] frames,
   output logic             sclk,
   output logic             sst,
   output logic             otrig,
   output logic             busy,
   output logic             frame_done,
   output logic [FRM_W-1:0] frame_cnt
);

   // ------------------------------------------------------------------
   // Divider
   // ------------------------------------------------------------------
   localparam int unsigned DCNT_W = $clog2(DIV);

   localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DIV - 1);
   localparam logic [DCNT_W-1:0] DCNT_HALF = DCNT_W'(DIV / 2);
   localparam logic [DCNT_W-1:0] DCNT_TICK = DCNT_W'(DIV / 2 - 1);

   localparam logic [CNT_W-1:0] LEAD_LOAD = CNT_W'(LEAD_TICKS);
   localparam logic [CNT_W-1:0] TAIL_LOAD = CNT_W'(TAIL_TICKS);
   localparam logic [CNT_W-1:0] READ_LOAD = CNT_W'(READ_TICKS);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   logic [DCNT_W-1:0] dcnt_q;
   logic [DCNT_W-1:0] dcnt_d;
   logic              sclk_q;
   logic              tick;

   // Next divider count: free-running 0..DIV-1.
   always_comb begin
      // NOTE: give every always_comb output a default first so no path can leave it unassigned and infer a latch.
      dcnt_d = dcnt_q + 1'b1;
      if (dcnt_q == DCNT_LAST) begin
         dcnt_d = '0;
      end
   end

   // The tick is the last cycle of the sclk high half; on that edge sclk falls
   // and the sequencer advances, so sst/otrig move with the sclk falling edge.
   assign tick = (dcnt_q == DCNT_TICK);

   // Divider counter and registered sclk, high while the count is in the first half.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         dcnt_q <= '0;
         sclk_q <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
         dcnt_q <= dcnt_d;
         sclk_q <= (dcnt_d < DCNT_HALF);
      end
   end

   // ------------------------------------------------------------------
   // Acquisition sequencer
   // ------------------------------------------------------------------
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LEAD,
      ST_EXPOSE,
      ST_TAIL,
      ST_READ
   } state_e;

   state_e           state_q;
   logic [CNT_W-1:0] cnt_q;         // ticks remaining in the current phase
   logic [CNT_W-1:0] exp_q;         // exposure latched at LEAD entry
   logic [FRM_W-1:0] frm_req_q;     // frames requested, latched at start
   logic [FRM_W-1:0] frame_cnt_q;
   logic             arm_q;         // start seen, waiting for the first tick
   logic             stop_pend_q;   // finish this frame then go idle
   logic             sst_q;
   logic             otrig_q;
   logic             busy_q;
   logic             frame_done_q;

   logic [FRM_W-1:0] frame_nxt;
   logic             phase_end;
   logic             last_frame;

   // A phase loaded with N lasts max(N,1) ticks: it ends on the tick where
   // the remaining count is 1 or already 0.
   assign phase_end  = tick && (cnt_q <= CNT_ONE);
   assign frame_nxt  = frame_cnt_q + 1'b1;
   assign last_frame = (frm_req_q != '0) && (frame_nxt == frm_req_q);

   // Sequencer state, phase counter and registered outputs.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         exp_q        <= '0;
         frm_req_q    <= '0;
         frame_cnt_q  <= '0;
         arm_q        <= 1'b0;
         stop_pend_q  <= 1'b0;
         sst_q        <= 1'b0;
         otrig_q      <= 1'b0;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         // Pulse outputs default low and are raised only on their edge.
         otrig_q      <= 1'b0;
         frame_done_q <= 1'b0;

         if (abort) begin
            // Abort beats start and stop; frame_cnt keeps its value.
            state_q     <= ST_IDLE;
            arm_q       <= 1'b0;
            stop_pend_q <= 1'b0;
            sst_q       <= 1'b0;
            busy_q      <= 1'b0;
         end else begin
            if (stop && busy_q) begin
               stop_pend_q <= 1'b1;
            end

            unique case (state_q)
               ST_IDLE: begin
                  if (start && !busy_q) begin
                     frm_req_q   <= frames;
                     frame_cnt_q <= '0;
                     arm_q       <= 1'b1;
                     busy_q      <= 1'b1;
                  end else if (arm_q && tick) begin
                     arm_q   <= 1'b0;
                     state_q <= ST_LEAD;
                     cnt_q   <= LEAD_LOAD;
                     exp_q   <= exposure;
                     sst_q   <= 1'b1;
                  end
               end

               ST_LEAD: begin
                  if (phase_end) begin
                     state_q <= ST_EXPOSE;
                     cnt_q   <= exp_q;
                  end else if (tick) begin
                     cnt_q <= cnt_q - 1'b1;
                  end
               end

               ST_EXPOSE: begin
                  if (phase_end) begin
                     state_q <= ST_TAIL;
                     cnt_q   <= TAIL_LOAD;
                     sst_q   <= 1'b0;
                  end else if (tick) begin
                     cnt_q <= cnt_q - 1'b1;
                  end
               end

               ST_TAIL: begin
                  if (phase_end) begin
                     state_q <= ST_READ;
                     cnt_q   <= READ_LOAD;
                     otrig_q <= 1'b1;
                  end else if (tick) begin
                     cnt_q <= cnt_q - 1'b1;
                  end
               end

               ST_READ: begin
                  if (phase_end) begin
                     frame_done_q <= 1'b1;
                     frame_cnt_q  <= frame_nxt;
                     // A stop arriving on this very clk still counts as pending.
                     if (stop_pend_q || stop || last_frame) begin
                        state_q     <= ST_IDLE;
                        stop_pend_q <= 1'b0;
                        busy_q      <= 1'b0;
                     end else begin
                        // Next frame starts on the same tick, no gap.
                        state_q <= ST_LEAD;
                        cnt_q   <= LEAD_LOAD;
                        exp_q   <= exposure;
                        sst_q   <= 1'b1;
                     end
                  end else if (tick) begin
                     cnt_q <= cnt_q - 1'b1;
                  end
               end

               default: begin
                  state_q <= ST_IDLE;
                  sst_q   <= 1'b0;
                  busy_q  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign sclk       = sclk_q;
   assign sst        = sst_q;
   assign otrig      = otrig_q;
   assign busy       = busy_q;
   assign frame_done = frame_done_q;
   assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_linesensor_timer.sv
// Directed testbench for linesensor_timer with default parameters.
// A monitor timestamps sst edges, otrig pulses and frame_done pulses in clk
// cycles; each scenario task compares those timestamps against hand-computed
// tick counts (1 tick = 8 clk).
module tb_linesensor_timer;

   localparam int TK = 8;   // clk cycles per tick

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        start = 1'b0;
   logic        stop = 1'b0;
   logic        abort = 1'b0;
   logic [31:0] exposure = 32'd0;
   logic [15:0] frames = 16'd0;
   logic        sclk;
   logic        sst;
   logic        otrig;
   logic        busy;
   logic        frame_done;
   logic [15:0] frame_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   linesensor_timer dut (
      .clk        (clk),
      .resetn     (resetn),
      .start      (start),
      .stop       (stop),
      .abort      (abort),
      .exposure   (exposure),
      .frames     (frames),
      .sclk       (sclk),
      .sst        (sst),
      .otrig      (otrig),
      .busy       (busy),
      .frame_done (frame_done),
      .frame_cnt  (frame_cnt)
   );

   always #5 clk = ~clk;

   // Event monitor: samples 1 time unit after each rising edge.
   int   cyc = 0;
   int   sst_r[$];
   int   sst_f[$];
   int   ot_r[$];
   int   fd_r[$];
   int   ot_hi = 0;
   int   fd_hi = 0;
   logic sst_p = 1'b0;
   logic ot_p = 1'b0;
   logic fd_p = 1'b0;

   always @(posedge clk) begin
      #1;
      cyc = cyc + 1;
      if (sst && !sst_p) sst_r.push_back(cyc);
      if (!sst && sst_p) sst_f.push_back(cyc);
      if (otrig && !ot_p) ot_r.push_back(cyc);
      if (frame_done && !fd_p) fd_r.push_back(cyc);
      if (otrig) ot_hi = ot_hi + 1;
      if (frame_done) fd_hi = fd_hi + 1;
      sst_p = sst;
      ot_p  = otrig;
      fd_p  = frame_done;
   end

   // Advance one clk; inputs change and outputs are read 2 units after the edge.
   task automatic step(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #2;
      end
   endtask

   function automatic int qsize(input int which);
      case (which)
         0:       return sst_r.size();
         1:       return sst_f.size();
         2:       return ot_r.size();
         default: return fd_r.size();
      endcase
   endfunction

   // Bounded wait for a monitor event count; an expired budget is a failure.
   task automatic wait_q(input string name, input int which, input int target, input int budget);
      int n;
      n = 0;
      while (qsize(which) < target && n < budget) begin
         step();
         n++;
      end
      n_tests++;
      if (qsize(which) < target) begin
         n_fail++;
         $display("FAIL %s: timeout, got %0d events want %0d", name, qsize(which), target);
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic test_reset();
      int highs;
      int rises;
      logic prev;
      step(3);
      n_tests++;
      if ({sclk, sst, otrig, busy, frame_done, frame_cnt} !== 21'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: got %h want 0", {sclk, sst, otrig, busy, frame_done, frame_cnt});
      end
      resetn = 1'b1;
      step(16);
      highs = 0;
      rises = 0;
      prev  = sclk;
      for (int i = 0; i < 32; i++) begin
         step();
         if (sclk) highs++;
         if (sclk && !prev) rises++;
         prev = sclk;
      end
      n_tests++;
      if (highs !== 16) begin
         n_fail++;
         $display("FAIL sclk_duty: got %0d high cycles want 16", highs);
      end
      n_tests++;
      if (rises !== 4) begin
         n_fail++;
         $display("FAIL sclk_period: got %0d rises in 32 clk want 4", rises);
      end
      n_tests++;
      if ({sst, otrig, busy, frame_done} !== 4'd0 || sst_r.size() !== 0 || ot_hi !== 0) begin
         n_fail++;
         $display("FAIL idle_quiet: got sst/otrig/busy/fd=%b rises=%0d want 0000/0", {sst, otrig, busy, frame_done}, sst_r.size());
      end
   endtask

   task automatic test_single();
      int br, bf, bo, bd, ohi;
      br = sst_r.size(); bf = sst_f.size(); bo = ot_r.size(); bd = fd_r.size(); ohi = ot_hi;
      exposure = 32'd100;
      frames   = 16'd1;
      pulse_start();
      n_tests++;
      if (busy !== 1'b1) begin
         n_fail++;
         $display("FAIL single_busy_after_start: got %b want 1", busy);
      end
      wait_q("single_done", 3, bd + 1, 4200);
      n_tests++;
      if (sst_f[bf] - sst_r[br] !== (5 + 100) * TK) begin
         n_fail++;
         $display("FAIL single_sst_len: got %0d want %0d", sst_f[bf] - sst_r[br], (5 + 100) * TK);
      end
      n_tests++;
      if (ot_r[bo] - sst_f[bf] !== 88 * TK) begin
         n_fail++;
         $display("FAIL single_otrig_delay: got %0d want %0d", ot_r[bo] - sst_f[bf], 88 * TK);
      end
      n_tests++;
      if (fd_r[bd] - sst_r[br] !== 479 * TK) begin
         n_fail++;
         $display("FAIL single_frame_len: got %0d want %0d", fd_r[bd] - sst_r[br], 479 * TK);
      end
      n_tests++;
      if (frame_cnt !== 16'd1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL single_end_state: got cnt=%0d busy=%b want 1/0", frame_cnt, busy);
      end
      step(100);
      n_tests++;
      if (ot_r.size() !== bo + 1 || ot_hi !== ohi + 1 || sst_r.size() !== br + 1) begin
         n_fail++;
         $display("FAIL single_pulses: got otrig=%0d hi=%0d lead=%0d want %0d/%0d/%0d",
                  ot_r.size(), ot_hi, sst_r.size(), bo + 1, ohi + 1, br + 1);
      end
   endtask

   task automatic test_back_to_back();
      int br, bf, bo, bd, fhi;
      br = sst_r.size(); bf = sst_f.size(); bo = ot_r.size(); bd = fd_r.size(); fhi = fd_hi;
      exposure = 32'd0;
      frames   = 16'd3;
      pulse_start();
      wait_q("b2b_done", 3, bd + 3, 3 * 380 * TK + 200);
      n_tests++;
      if (sst_f[bf] - sst_r[br] !== (5 + 1) * TK) begin
         n_fail++;
         $display("FAIL b2b_expose_min: got %0d want %0d", sst_f[bf] - sst_r[br], 6 * TK);
      end
      n_tests++;
      if (fd_r[bd + 1] - fd_r[bd] !== 380 * TK || fd_r[bd + 2] - fd_r[bd + 1] !== 380 * TK) begin
         n_fail++;
         $display("FAIL b2b_spacing: got %0d,%0d want %0d", fd_r[bd + 1] - fd_r[bd],
                  fd_r[bd + 2] - fd_r[bd + 1], 380 * TK);
      end
      n_tests++;
      if (sst_r[br + 1] !== fd_r[bd] || sst_r[br + 2] !== fd_r[bd + 1]) begin
         n_fail++;
         $display("FAIL b2b_no_gap: got lead=%0d,%0d want %0d,%0d", sst_r[br + 1], sst_r[br + 2],
                  fd_r[bd], fd_r[bd + 1]);
      end
      step(100);
      n_tests++;
      if (ot_r.size() !== bo + 3 || fd_hi !== fhi + 3 || sst_r.size() !== br + 3) begin
         n_fail++;
         $display("FAIL b2b_counts: got otrig=%0d fd_hi=%0d lead=%0d want %0d/%0d/%0d",
                  ot_r.size(), fd_hi, sst_r.size(), bo + 3, fhi + 3, br + 3);
      end
      n_tests++;
      if (frame_cnt !== 16'd3 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_end_state: got cnt=%0d busy=%b want 3/0", frame_cnt, busy);
      end
   endtask

   task automatic test_stop();
      int br, bd;
      br = sst_r.size(); bd = fd_r.size();
      exposure = 32'd20;
      frames   = 16'd0;
      pulse_start();
      wait_q("stop_second_lead", 0, br + 2, 2 * 399 * TK + 200);
      step(60);
      stop = 1'b1;
      step();
      stop = 1'b0;
      n_tests++;
      if (sst !== 1'b1 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL stop_not_immediate: got sst=%b busy=%b want 1/1", sst, busy);
      end
      wait_q("stop_done", 3, bd + 2, 399 * TK + 200);
      n_tests++;
      if (fd_r[bd + 1] - sst_r[br + 1] !== 399 * TK) begin
         n_fail++;
         $display("FAIL stop_frame_len: got %0d want %0d", fd_r[bd + 1] - sst_r[br + 1], 399 * TK);
      end
      step(100);
      n_tests++;
      if (frame_cnt !== 16'd2 || busy !== 1'b0 || sst_r.size() !== br + 2 || fd_r.size() !== bd + 2) begin
         n_fail++;
         $display("FAIL stop_end_state: got cnt=%0d busy=%b lead=%0d want 2/0/%0d",
                  frame_cnt, busy, sst_r.size(), br + 2);
      end
   endtask

   task automatic test_abort();
      int br, bf, bo, bd;
      br = sst_r.size(); bf = sst_f.size(); bo = ot_r.size(); bd = fd_r.size();
      exposure = 32'd10;
      frames   = 16'd1;
      pulse_start();
      wait_q("abort_tail_entry", 1, bf + 1, 300);
      step(20);
      abort = 1'b1;
      step();
      abort = 1'b0;
      n_tests++;
      if (sst !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_next_clk: got sst=%b busy=%b want 0/0", sst, busy);
      end
      step(3000);
      n_tests++;
      if (ot_r.size() !== bo || fd_r.size() !== bd || frame_cnt !== 16'd0) begin
         n_fail++;
         $display("FAIL abort_quiet: got otrig=%0d fd=%0d cnt=%0d want %0d/%0d/0",
                  ot_r.size(), fd_r.size(), frame_cnt, bo, bd);
      end
      step(10);
      pulse_start();
      wait_q("abort_restart_done", 3, bd + 1, 389 * TK + 200);
      n_tests++;
      if (sst_f[bf + 1] - sst_r[br + 1] !== 15 * TK || fd_r[bd] - sst_r[br + 1] !== 389 * TK) begin
         n_fail++;
         $display("FAIL abort_restart_frame: got sst=%0d frame=%0d want %0d/%0d",
                  sst_f[bf + 1] - sst_r[br + 1], fd_r[bd] - sst_r[br + 1], 15 * TK, 389 * TK);
      end
      n_tests++;
      if (frame_cnt !== 16'd1 || ot_r.size() !== bo + 1) begin
         n_fail++;
         $display("FAIL abort_restart_count: got cnt=%0d otrig=%0d want 1/%0d", frame_cnt, ot_r.size(), bo + 1);
      end
   endtask

   task automatic test_start_abort();
      int br;
      br = sst_r.size();
      start = 1'b1;
      abort = 1'b1;
      step();
      start = 1'b0;
      abort = 1'b0;
      step(40);
      n_tests++;
      if (busy !== 1'b0 || sst_r.size() !== br) begin
         n_fail++;
         $display("FAIL start_abort_same_clk: got busy=%b lead=%0d want 0/%0d", busy, sst_r.size(), br);
      end
   endtask

   task automatic test_exposure_change();
      int br, bf, bd;
      br = sst_r.size(); bf = sst_f.size(); bd = fd_r.size();
      exposure = 32'd50;
      frames   = 16'd2;
      pulse_start();
      wait_q("expchg_lead", 0, br + 1, 200);
      step(60);
      exposure = 32'd10;
      frames   = 16'd7;
      pulse_start();
      wait_q("expchg_done", 3, bd + 2, (429 + 389) * TK + 200);
      n_tests++;
      if (sst_f[bf] - sst_r[br] !== 55 * TK) begin
         n_fail++;
         $display("FAIL expchg_current_frame: got %0d want %0d", sst_f[bf] - sst_r[br], 55 * TK);
      end
      n_tests++;
      if (sst_f[bf + 1] - sst_r[br + 1] !== 15 * TK) begin
         n_fail++;
         $display("FAIL expchg_next_frame: got %0d want %0d", sst_f[bf + 1] - sst_r[br + 1], 15 * TK);
      end
      step(100);
      n_tests++;
      if (frame_cnt !== 16'd2 || busy !== 1'b0 || fd_r.size() !== bd + 2) begin
         n_fail++;
         $display("FAIL start_while_busy: got cnt=%0d busy=%b fd=%0d want 2/0/%0d",
                  frame_cnt, busy, fd_r.size(), bd + 2);
      end
   endtask

   task automatic test_reset_mid_frame();
      int br;
      br = sst_r.size();
      exposure = 32'd30;
      frames   = 16'd0;
      pulse_start();
      wait_q("rst_mid_lead", 0, br + 1, 200);
      step(10);
      resetn = 1'b0;
      #1;
      n_tests++;
      if ({sclk, sst, otrig, busy, frame_done, frame_cnt} !== 21'd0) begin
         n_fail++;
         $display("FAIL reset_async: got %h want 0", {sclk, sst, otrig, busy, frame_done, frame_cnt});
      end
      step(3);
      resetn = 1'b1;
      step(2);
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_stop();
      test_abort();
      test_start_abort();
      test_exposure_change();
      test_reset_mid_frame();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
